// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- pipeline control unit for the five-stage core.
//
// Purpose:
//   * Merges ID and EX stall requests into the per-stage stall vector
//     that holds PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
//   * Sequences multi-cycle EX operations (MAC, divide) with a down-counter
//     held in a small IDLE/RUN/DONE state machine.
//   * Optionally generates a one-cycle pipeline flush plus redirect PC on
//     an exception commit.
//
// Optional feature macro: PIPE_FLUSH_EN
//   defined   -> exc_req / exc_vec ports exist; flush and new_pc are
//                registered and the FSM can be aborted by a flush.
//   undefined -> no exception ports; flush tied 0, new_pc tied 32'h0,
//                and the FSM has no abort path.
//
// Parameters:
//   MC_W          width of mc_len and of the internal down-counter.
//
// Ports:
//   clk           rising-edge clock.
//   rst           asynchronous reset, active low.
//   stallreq_id   ID-stage load-use stall request (level).
//   stallreq_ex   EX-stage external stall request (level).
//   mc_start      EX issues a multi-cycle operation this cycle.
//   mc_len        total stall cycles of that operation (0 = ignored).
//   exc_req       exception commit request      (PIPE_FLUSH_EN only).
//   exc_vec       exception handler address     (PIPE_FLUSH_EN only).
//   mc_done       one-cycle pulse: multi-cycle result valid this cycle.
//   busy          FSM is not IDLE.
//   stall         [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB, 1 = hold.
//   flush         clear all pipeline registers this cycle.
//   new_pc        redirect address, meaningful while flush = 1.
//   stall_cycles  saturating count of cycles with stall[0] = 1.
//   dbg_state     current FSM state (0 IDLE, 1 RUN, 2 DONE) for observation.
//
// Handshake: mc_start is a request that is accepted only in IDLE with a
// non-zero mc_len; there is no back-pressure. An accepted operation of
// length N stalls EX for exactly N cycles (including the issue cycle) and
// then raises mc_done for exactly one cycle, unless a flush or reset aborts
// it first, in which case mc_done is never raised for that operation.
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int MC_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallreq_id,
    input  logic            stallreq_ex,
    input  logic            mc_start,
    input  logic [MC_W-1:0] mc_len,
`ifdef PIPE_FLUSH_EN
    input  logic            exc_req,
    input  logic [31:0]     exc_vec,
`endif
    output logic            mc_done,
    output logic            busy,
    output logic [5:0]      stall,
    output logic            flush,
    output logic [31:0]     new_pc,
    output logic [31:0]     stall_cycles,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [MC_W-1:0] CNT_ONE   = {{(MC_W-1){1'b0}}, 1'b1};
    localparam logic [5:0]      STALL_EX  = 6'b001111;
    localparam logic [5:0]      STALL_ID  = 6'b000111;
    localparam logic [5:0]      STALL_NONE = 6'b000000;

    state_e          state_q, state_d;
    logic [MC_W-1:0] cnt_q, cnt_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;

    logic            flush_w;
    logic [31:0]     new_pc_w;

    logic            mc_accept;
    logic            ex_stall;

    // -----------------------------------------------------------------------
    // Exception flush: exc_req in cycle T produces a flush in T+1 only.
    // A request arriving during the flush cycle itself is dropped, so a
    // held exc_req cannot produce back-to-back flushes.
    // -----------------------------------------------------------------------
`ifdef PIPE_FLUSH_EN
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;

    always_comb begin
        flush_d  = exc_req & ~flush_q;
        new_pc_d = new_pc_q;
        if (flush_d) begin
            new_pc_d = exc_vec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_q  <= 1'b0;
            new_pc_q <= 32'h0;
        end else begin
            flush_q  <= flush_d;
            new_pc_q <= new_pc_d;
        end
    end

    assign flush_w  = flush_q;
    assign new_pc_w = new_pc_q;
`else
    assign flush_w  = 1'b0;
    assign new_pc_w = 32'h0;
`endif

    // -----------------------------------------------------------------------
    // Multi-cycle sequencer. The counter loads N-1 on issue, so the issue
    // cycle plus N-1 RUN cycles give N stall cycles before DONE.
    // -----------------------------------------------------------------------
    assign mc_accept = (state_q == ST_IDLE) && mc_start && (mc_len != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mc_accept) begin
                    cnt_d   = mc_len - CNT_ONE;
                    state_d = (mc_len == CNT_ONE) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // Counter of 0 cannot occur in RUN; treat it like 1 so a
                // corrupted counter cannot wrap into a 2^MC_W-cycle stall.
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
`ifdef PIPE_FLUSH_EN
        // A flush aborts whatever the sequencer is doing, including an
        // operation issued in the same cycle as the flush.
        if (flush_w) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Stall vector: flush beats everything, EX stall beats ID stall.
    // The issue cycle already counts as a stall cycle, hence mc_accept.
    // -----------------------------------------------------------------------
    assign ex_stall = mc_accept || (state_q == ST_RUN) || stallreq_ex;

    always_comb begin
        stall = STALL_NONE;
        if (flush_w) begin
            stall = STALL_NONE;
        end else if (ex_stall) begin
            stall = STALL_EX;
        end else if (stallreq_id) begin
            stall = STALL_ID;
        end
    end

    // An operation caught by a flush in its DONE cycle must not report.
    assign mc_done = (state_q == ST_DONE) && !flush_w;
    assign busy    = (state_q != ST_IDLE);

    // -----------------------------------------------------------------------
    // Saturating stall-cycle counter (counts PC-hold cycles).
    // -----------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 32'h0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign flush        = flush_w;
    assign new_pc       = new_pc_w;
    assign stall_cycles = stall_cnt_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl.
//
// The reference model tracks each accepted multi-cycle operation as a
// window of absolute cycle numbers [issue, issue+N]: stall while inside
// [issue, issue+N-1], done at issue+N. Flush is modelled as a pending flag
// carried from the exception cycle to the next one. Outputs are compared on
// every falling edge; inputs change just after rising edges.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int MC_W = 6;

    logic            clk;
    logic            rst;
    logic            stallreq_id;
    logic            stallreq_ex;
    logic            mc_start;
    logic [MC_W-1:0] mc_len;
    logic            exc_req;
    logic [31:0]     exc_vec;
    logic            mc_done;
    logic            busy;
    logic [5:0]      stall;
    logic            flush;
    logic [31:0]     new_pc;
    logic [31:0]     stall_cycles;
    logic [1:0]      dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    pipe_ctrl #(.MC_W(MC_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .mc_start     (mc_start),
        .mc_len       (mc_len),
`ifdef PIPE_FLUSH_EN
        .exc_req      (exc_req),
        .exc_vec      (exc_vec),
`endif
        .mc_done      (mc_done),
        .busy         (busy),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_cycles (stall_cycles),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int      cyc = 0;
    bit      m_active = 0;
    int      m_start_c = 0;
    int      m_end_c = 0;
    bit      m_flush_pend = 0;
    logic [31:0] m_vec = 32'h0;
    longint  m_count = 0;

    always @(negedge clk) begin
        bit         e_busy, e_run, e_issue, e_flush, e_ex, e_done;
        logic [5:0] e_stall;
        logic [31:0] e_cnt;
        if (!rst) begin
            m_active     = 0;
            m_flush_pend = 0;
            m_count      = 0;
        end
        e_busy  = m_active && (cyc > m_start_c) && (cyc <= m_end_c);
        e_run   = e_busy && (cyc < m_end_c);
        e_issue = !e_busy && mc_start && (mc_len != 0);
        e_flush = m_flush_pend;
        e_ex    = e_issue || e_run || stallreq_ex;
        if (e_flush)          e_stall = 6'b000000;
        else if (e_ex)        e_stall = 6'b001111;
        else if (stallreq_id) e_stall = 6'b000111;
        else                  e_stall = 6'b000000;
        e_done  = e_busy && (cyc == m_end_c) && !e_flush;
        e_cnt   = (m_count > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_count[31:0];

        check("m_stall", {26'h0, stall}, {26'h0, e_stall});
        check("m_busy", {31'h0, busy}, {31'h0, e_busy});
        check("m_mc_done", {31'h0, mc_done}, {31'h0, e_done});
        check("m_flush", {31'h0, flush}, {31'h0, e_flush});
        check("m_stall_cycles", stall_cycles, e_cnt);
`ifdef PIPE_FLUSH_EN
        if (e_flush) check("m_new_pc", new_pc, m_vec);
`else
        check("m_new_pc", new_pc, 32'h0);
`endif

        if (rst) begin
            if (e_stall[0]) m_count++;
            if (e_flush) begin
                m_active = 0;
            end else begin
                if (m_active && cyc >= m_end_c) m_active = 0;
                if (e_issue) begin
                    m_active  = 1;
                    m_start_c = cyc;
                    m_end_c   = cyc + int'(mc_len);
                end
            end
`ifdef PIPE_FLUSH_EN
            m_flush_pend = exc_req && !e_flush;
            if (m_flush_pend) m_vec = exc_vec;
`else
            m_flush_pend = 0;
`endif
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic s, input logic [MC_W-1:0] l, input logic id,
                         input logic ex, input logic er, input logic [31:0] v);
        @(posedge clk);
        #1;
        mc_start    = s;
        mc_len      = l;
        stallreq_id = id;
        stallreq_ex = ex;
        exc_req     = er;
        exc_vec     = v;
    endtask

    task automatic idle_cyc();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // Settle point for directed literal checks, clear of both model and edges.
    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] sc0;

    initial begin
        rst = 1'b0;
        mc_start = 1'b0; mc_len = '0; stallreq_id = 1'b0; stallreq_ex = 1'b0;
        exc_req = 1'b0; exc_vec = 32'h0;

        // Reset
        repeat (3) @(posedge clk);
        sample();
        check("rst_stall", {26'h0, stall}, 32'h0);
        check("rst_flush", {31'h0, flush}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_stall_cycles", stall_cycles, 32'h0);
        @(posedge clk); #1; rst = 1'b1;
        repeat (5) idle_cyc();
        sample();
        check("idle_stall", {26'h0, stall}, 32'h0);
        check("idle_busy", {31'h0, busy}, 32'h0);
        check("idle_mc_done", {31'h0, mc_done}, 32'h0);
        check("idle_stall_cycles", stall_cycles, 32'h0);

        // mc_len = 4
        drive(1'b1, 6'd4, 1'b0, 1'b0, 1'b0, 32'h0);
        sample();
        check("len4_t0_stall", {26'h0, stall}, 32'h0000_000F);
        check("len4_t0_busy", {31'h0, busy}, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            idle_cyc();
            sample();
            check("len4_run_stall", {26'h0, stall}, 32'h0000_000F);
            check("len4_run_busy", {31'h0, busy}, 32'h1);
            check("len4_run_done", {31'h0, mc_done}, 32'h0);
        end
        idle_cyc();
        sample();
        check("len4_t4_stall", {26'h0, stall}, 32'h0);
        check("len4_t4_done", {31'h0, mc_done}, 32'h1);
        check("len4_t4_busy", {31'h0, busy}, 32'h1);
        check("len4_t4_stall_cycles", stall_cycles, 32'd4);
        idle_cyc();
        sample();
        check("len4_t5_busy", {31'h0, busy}, 32'h0);
        check("len4_t5_done", {31'h0, mc_done}, 32'h0);

        // mc_len = 1
        drive(1'b1, 6'd1, 1'b0, 1'b0, 1'b0, 32'h0);
        sample();
        check("len1_t0_stall", {26'h0, stall}, 32'h0000_000F);
        idle_cyc();
        sample();
        check("len1_t1_done", {31'h0, mc_done}, 32'h1);
        check("len1_t1_stall", {26'h0, stall}, 32'h0);

        // mc_len = 0 is ignored
        drive(1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        sample();
        check("len0_stall", {26'h0, stall}, 32'h0);
        idle_cyc();
        sample();
        check("len0_done", {31'h0, mc_done}, 32'h0);
        check("len0_busy", {31'h0, busy}, 32'h0);
        sc0 = stall_cycles;

        // mc_len = 63
        drive(1'b1, 6'd63, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (62) idle_cyc();
        idle_cyc();
        sample();
        check("len63_done", {31'h0, mc_done}, 32'h1);
        check("len63_stall_delta", stall_cycles - sc0, 32'd63);

        // Priority
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 32'h0);
        sample();
        check("prio_id", {26'h0, stall}, 32'h0000_0007);
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 32'h0);
        sample();
        check("prio_id_ex", {26'h0, stall}, 32'h0000_000F);
        idle_cyc();

        // Second mc_start during RUN is ignored
        drive(1'b1, 6'd5, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 6'd3, 1'b0, 1'b0, 1'b0, 32'h0);
        sample();
        check("restart_busy", {31'h0, busy}, 32'h1);
        repeat (3) idle_cyc();
        idle_cyc();
        sample();
        check("restart_done_t5", {31'h0, mc_done}, 32'h1);
        idle_cyc();

`ifdef PIPE_FLUSH_EN
        // Flush aborting a RUN
        drive(1'b1, 6'd10, 1'b0, 1'b0, 1'b0, 32'h0);
        idle_cyc();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'hBFC0_0380);
        idle_cyc();
        sample();
        check("flush_t3_flush", {31'h0, flush}, 32'h1);
        check("flush_t3_new_pc", new_pc, 32'hBFC0_0380);
        check("flush_t3_stall", {26'h0, stall}, 32'h0);
        check("flush_t3_done", {31'h0, mc_done}, 32'h0);
        idle_cyc();
        sample();
        check("flush_t4_busy", {31'h0, busy}, 32'h0);
        check("flush_t4_flush", {31'h0, flush}, 32'h0);
        repeat (12) idle_cyc();

        // exc_req with mc_start, and exc_req held into the flush cycle
        drive(1'b1, 6'd3, 1'b0, 1'b0, 1'b1, 32'h8000_0180);
        sample();
        check("exc_mc_t0_stall", {26'h0, stall}, 32'h0000_000F);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
        sample();
        check("exc_mc_t1_flush", {31'h0, flush}, 32'h1);
        check("exc_mc_t1_new_pc", new_pc, 32'h8000_0180);
        idle_cyc();
        sample();
        check("exc_mc_t2_flush", {31'h0, flush}, 32'h0);
        check("exc_mc_t2_busy", {31'h0, busy}, 32'h0);
        repeat (5) idle_cyc();
`endif

        // Asynchronous reset mid-RUN
        drive(1'b1, 6'd8, 1'b0, 1'b0, 1'b0, 32'h0);
        idle_cyc();
        idle_cyc();
        #2;
        rst = 1'b0;
        #1;
        check("arst_busy", {31'h0, busy}, 32'h0);
        check("arst_stall_cycles", stall_cycles, 32'h0);
        @(posedge clk); #1; rst = 1'b1;
        repeat (12) idle_cyc();

        // Randomized traffic
        repeat (2000) begin
            logic            s, id, ex, er;
            logic [MC_W-1:0] l;
            s  = ($urandom_range(0, 3) == 0);
            l  = ($urandom_range(0, 9) == 0) ? 6'd63 : MC_W'($urandom_range(0, 12));
            id = ($urandom_range(0, 7) == 0);
            ex = ($urandom_range(0, 7) == 0);
`ifdef PIPE_FLUSH_EN
            er = ($urandom_range(0, 24) == 0);
`else
            er = 1'b0;
`endif
            drive(s, l, id, ex, er, $urandom);
        end
        repeat (70) idle_cyc();
        sample();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage core. It merges stall requests from ID and EX into the per-stage stall vector that holds PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It sequences multi-cycle EX operations (multiply-accumulate, divide) with an internal down-counter. It also generates the pipeline flush and redirect PC on exceptions.

## Interface
Parameters:
- `MC_W`, default 6: width of the multi-cycle length field and of the internal counter.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous reset, active-low; `rst`=0 resets immediately, independent of `clk`.
- `stallreq_id`, input, 1: ID-stage hazard stall request (load-use); level, combinational.
- `stallreq_ex`, input, 1: EX-stage external stall request; level, combinational.
- `mc_start`, input, 1: EX issues a multi-cycle operation this cycle.
- `mc_len`, input, MC_W: total stall cycles for the operation, 1..2^MC_W-1.
- `mc_done`, output, 1: one-cycle pulse; the EX multi-cycle result is valid this cycle.
- `busy`, output, 1: FSM not in IDLE.
- `stall`, output, 6: [0]=PC, [1]=IF, [2]=ID, [3]=EX, [4]=MEM, [5]=WB; 1 = hold that stage.
- `exc_req`, input, 1: exception commit request; present only with `PIPE_FLUSH_EN`.
- `exc_vec`, input, 32: exception handler address; present only with `PIPE_FLUSH_EN`.
- `flush`, output, 1: clear all pipeline registers this cycle.
- `new_pc`, output, 32: redirect address, valid while `flush`=1.
- `stall_cycles`, output, 32: count of cycles with `stall[0]`=1; saturates at 0xFFFFFFFF.

## Operation
- FSM states:
  - IDLE
  - RUN: counting down the multi-cycle operation.
  - DONE: one cycle, `mc_done`=1.
- IDLE, `mc_start`=1, `mc_len`=N≥1:
  - Counter loads N-1.
  - Next state is DONE if N=1, else RUN.
  - `mc_start` with `mc_len`=0 is ignored.
- RUN:
  - If counter=1: go to DONE and set counter to 0.
  - Otherwise decrement the counter.
- DONE: return to IDLE unconditionally.
- `mc_start` is ignored in RUN and DONE.
- Stall vector priority, evaluated combinationally each cycle:
  1. `flush`=1 → 6'b000000.
  2. EX stall → 6'b001111. EX stall = (IDLE & `mc_start` & `mc_len`≠0) | RUN | `stallreq_ex`.
  3. `stallreq_id` → 6'b000111.
  4. Otherwise 6'b000000.
- `busy` = (state ≠ IDLE).
- `stall_cycles` increments by 1 each cycle `stall[0]`=1, holding at 0xFFFFFFFF.

## Timing
- Reset (`rst`=0), asynchronous:
  - State IDLE, counter 0.
  - `flush`=0, `new_pc`=0, `mc_done`=0, `busy`=0, `stall_cycles`=0.
  - `stall` is 0 whenever no request inputs are asserted.
- Multi-cycle latency for `mc_len`=N, issued at T0:
  - `stall`=001111 during T0..T(N-1).
  - `stall`=0 and `mc_done`=1 at TN.
  - EX/MEM captures the result at the end of TN.
- `stall`, `busy` and `mc_done` are decoded from state and inputs with no added register stage.
- Flush (with macro):
  - `exc_req`=1 at cycle T causes `flush`=1 and `new_pc`=`exc_vec`(T) at T+1, for exactly one cycle.
  - At T+1 the FSM is forced to IDLE, the counter to 0, and no `mc_done` is issued.
  - `exc_req`=1 during the flush cycle itself is ignored.
- Simultaneous events:
  - `exc_req` and `mc_start` in the same cycle: both take effect at T. `stall`=001111 at T; at T+1 the flush aborts the operation.
  - `stallreq_ex` and RUN together: a single stall; the counter still decrements.
- Reset asserted mid-RUN aborts the operation immediately; no `mc_done` is issued.

## Configuration
- `PIPE_FLUSH_EN` defined:
  - `exc_req` and `exc_vec` ports exist.
  - Flush logic and its registers are built as above.
- Not defined:
  - Ports are absent.
  - `flush` is tied 0 and `new_pc` is tied 32'h0.
  - The FSM has no abort path.

## Test plan
- Reset: hold `rst`=0 with all request inputs low → `stall`=0, `flush`=0, `busy`=0, `stall_cycles`=0. Release; idle 5 cycles → outputs unchanged.
- Multi-cycle: `mc_start`=1, `mc_len`=4 at T0 → `stall`=001111 at T0–T3, `mc_done`=1 only at T4, `busy`=1 at T1–T4, `stall_cycles`=4.
- Boundaries:
  - `mc_len`=1 → one stall cycle, then `mc_done`.
  - `mc_len`=0 → no stall, no `mc_done`.
  - `mc_len`=63 → 63 stall cycles.
- Priority: `stallreq_id`=1 alone → 000111. With `stallreq_ex`=1 added → 001111. A second `mc_start` during RUN is ignored; the done cycle is unchanged.
- Flush (macro on): start `mc_len`=10, then `exc_req`=1, `exc_vec`=0xBFC00380 at T2 → at T3 `flush`=1, `new_pc`=0xBFC00380, `stall`=0. At T4 state IDLE; `mc_done` is never asserted.
- Reset mid-RUN: assert `rst`=0 asynchronously between edges at T2 of `mc_len`=8 → `busy`=0 and `stall_cycles`=0 at once. After release no `mc_done` appears.
